// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment display path.
//   ACTIVE_LOW_DEF : default board polarity (1 = pins are active-low)
//   SEG_W_DEF      : default segment count per digit (a..g, bit0 = a)
//   scan_state_t   : scanner FSM states
//   pol()          : maps a logical "lit" bit to the pin level for a given polarity
package seg_disp_pkg;

  localparam bit          ACTIVE_LOW_DEF = 1'b1;
  localparam int unsigned SEG_W_DEF      = 7;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_t;

  // Logical 1 = lit; the returned value is the level to drive on the pin.
  function automatic logic pol(input logic x, input bit active_low);
    return active_low ? ~x : x;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timer for multiplexed display scanners.
// Counts 0..REFRESH_DIV-1 while enabled and flags the leading blank window of each slot.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : advance the counter this cycle
//   clear_i      : force the counter to 0 next cycle (wins over en_i)
//   cnt_o        : current position within the slot
//   in_blank_o   : cnt_o < BLANK_CYCLES
//   slot_wrap_o  : last cycle of the slot while advancing; counter returns to 0 next cycle
module scan_prescaler #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  localparam int unsigned CntW        = $clog2(REFRESH_DIV)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            clear_i,
  output logic [CntW-1:0] cnt_o,
  output logic            in_blank_o,
  output logic            slot_wrap_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_end;

  assign at_end = (cnt_q == CntW'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign in_blank_o  = (32'(cnt_q) < BLANK_CYCLES);
  assign slot_wrap_o = en_i && !clear_i && at_end;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with per-frame snapshot and inter-digit blanking.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; 0 = display dark
//   seg_in      : digit d pattern at [d*SEG_W +: SEG_W], 1 = segment lit
//   dp_in       : per-digit decimal point, 1 = lit
//   blank_mask  : 1 = digit d forced dark
//   an_out      : one-hot digit enables (pin polarity)
//   seg_out     : segment drive (pin polarity)
//   dp_out      : decimal point drive (pin polarity)
//   digit_idx   : digit owning the current slot
//   frame_tick  : one-cycle pulse when a new snapshot is taken
module seven_seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SEG_W        = SEG_W_DEF,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = ACTIVE_LOW_DEF,
  localparam int unsigned IdxW        = $clog2(NUM_DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        dp_out,
  output logic [IdxW-1:0]             digit_idx,
  output logic                        frame_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  // Every slot starts in BLANK unless there is no blank window at all.
  localparam scan_state_t SlotEntry = (BLANK_CYCLES == 0) ? StShow : StBlank;

  scan_state_t                 state_q, state_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [CntW-1:0]             cnt;
  logic                        in_blank, slot_wrap;
  logic                        running, presc_en, presc_clear, last_digit, load_snap;

  logic [NUM_DIGITS*SEG_W-1:0] snap_seg_q;
  logic [NUM_DIGITS-1:0]       snap_dp_q, snap_blank_q;

  logic                        lit_show;
  logic [NUM_DIGITS-1:0]       onehot, an_lit, an_d, an_q;
  logic [SEG_W-1:0]            seg_lit, seg_d, seg_q;
  logic                        dp_d, dp_q, tick_q;

  assign running     = (state_q != StIdle);
  assign presc_en    = running && en;
  // Holding the counter cleared while idle means a restart always begins at slot position 0.
  assign presc_clear = !running || !en;
  assign last_digit  = (idx_q == IdxW'(NUM_DIGITS - 1));

  scan_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (presc_en),
    .clear_i     (presc_clear),
    .cnt_o       (cnt),
    .in_blank_o  (in_blank),
    .slot_wrap_o (slot_wrap)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_snap = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d   = SlotEntry;
          idx_d     = '0;
          load_snap = 1'b1;
        end
      end
      StBlank, StShow: begin
        if (!en) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (slot_wrap) begin
          state_d = SlotEntry;
          if (last_digit) begin
            idx_d     = '0;
            load_snap = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if ((state_q == StBlank) && (32'(cnt) + 32'd1 == BLANK_CYCLES)) begin
          state_d = StShow;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output mux works on the current state; the result is registered, giving one cycle of latency.
  always_comb begin
    lit_show = (state_q == StShow) && !in_blank;
    onehot   = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx_q;
    an_lit   = (lit_show && !snap_blank_q[idx_q]) ? onehot : '0;
    seg_lit  = lit_show ? snap_seg_q[32'(idx_q) * SEG_W +: SEG_W] : '0;
    an_d     = '0;
    seg_d    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = pol(an_lit[i], ACTIVE_LOW);
    for (int i = 0; i < SEG_W; i++) seg_d[i] = pol(seg_lit[i], ACTIVE_LOW);
    dp_d = pol(lit_show && snap_dp_q[idx_q], ACTIVE_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      snap_seg_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      an_q         <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_q        <= {SEG_W{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      tick_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load_snap) begin
        snap_seg_q   <= seg_in;
        snap_dp_q    <= dp_in;
        snap_blank_q <= blank_mask;
      end
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= load_snap;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, 8-cycle slots, 2 blank cycles,
// active-low), plus an active-high instance with no blank window.
module tb_seven_seg_scan_driver;

  localparam int unsigned RD = 8;
  localparam int unsigned BL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        en_hi;
  logic [27:0] seg_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;

  logic [3:0]  an_out, an_hi;
  logic [6:0]  seg_out, seg_hi;
  logic        dp_out, dp_hi;
  logic [1:0]  digit_idx, idx_hi;
  logic        frame_tick, tick_hi;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       tick;
  } obs_t;

  obs_t obs;
  obs_t exp_q[$];

  assign obs = {an_out, seg_out, dp_out, digit_idx, frame_tick};

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS   (4),
    .SEG_W        (7),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS   (4),
    .SEG_W        (7),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (0),
    .ACTIVE_LOW   (1'b0)
  ) dut_hi (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_hi),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .an_out     (an_hi),
    .seg_out    (seg_hi),
    .dp_out     (dp_hi),
    .digit_idx  (idx_hi),
    .frame_tick (tick_hi)
  );

  // Reference model of the active-low instance: one expected observation per clock edge.
  bit          m_run;
  int          m_cnt, m_idx;
  logic [27:0] m_seg;
  logic [3:0]  m_dp, m_blank;

  always @(posedge clk) begin
    obs_t       e;
    logic [3:0] lit;
    bit         show, tick;
    if (rst_n !== 1'b1) begin
      m_run = 0; m_cnt = 0; m_idx = 0;
      m_seg = '0; m_dp = '0; m_blank = '0;
      e = {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
    end else begin
      lit  = '0;
      show = m_run && (m_cnt >= BL);
      if (show && !m_blank[m_idx]) lit[m_idx] = 1'b1;
      e.an  = ~lit;
      e.seg = show ? ~m_seg[m_idx*7 +: 7] : 7'h7F;
      e.dp  = show ? ~m_dp[m_idx] : 1'b1;
      tick  = 0;
      if (!m_run) begin
        if (en) begin
          m_run = 1; m_cnt = 0; m_idx = 0; tick = 1;
          m_seg = seg_in; m_dp = dp_in; m_blank = blank_mask;
        end
      end else if (!en) begin
        m_run = 0; m_cnt = 0; m_idx = 0;
      end else if (m_cnt == RD - 1) begin
        m_cnt = 0;
        if (m_idx == 3) begin
          m_idx = 0; tick = 1;
          m_seg = seg_in; m_dp = dp_in; m_blank = blank_mask;
        end else begin
          m_idx++;
        end
      end else begin
        m_cnt++;
      end
      e.idx  = 2'(m_idx);
      e.tick = tick;
    end
    exp_q.push_back(e);
  end

  // At most one anode lit on either instance, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(~an_out) || !$onehot0(an_hi)) begin
        errors++;
        $display("FAIL onehot: an_out=%b an_hi=%b, required at most one lit", an_out, an_hi);
      end
    end
  end

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0; en = 1'b1; en_hi = 1'b0;
    seg_in = {7'h06, 7'h5B, 7'h4F, 7'h66}; dp_in = 4'b0100; blank_mask = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== obs_t'({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0})) begin
      errors++; $display("FAIL reset_state: got %h required %h", obs,
                         obs_t'({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}));
    end
    exp_q.delete();
    rst_n = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL reset_sb c=%0d: no expected entry", c);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL reset_sb c=%0d: got %h required %h", c, obs, e); end
      end
      if (c <= 3) begin
        checks++;
        if (an_out !== 4'hF) begin errors++; $display("FAIL lead_blank c=%0d: an=%b required 1111", c, an_out); end
      end
      if (c >= 4 && c <= 9) begin
        checks++;
        if (an_out !== 4'hE || seg_out !== 7'h19 || dp_out !== 1'b1) begin
          errors++; $display("FAIL digit0 c=%0d: an=%b seg=%h dp=%b required 1110 19 1", c, an_out, seg_out, dp_out);
        end
      end
      if (c == 10 || c == 11) begin
        checks++;
        if (an_out !== 4'hF) begin errors++; $display("FAIL gap c=%0d: an=%b required 1111", c, an_out); end
      end
      if (c == 12) begin
        checks++;
        if (an_out !== 4'hD || seg_out !== 7'h30 || dp_out !== 1'b1) begin
          errors++; $display("FAIL digit1 c=%0d: an=%b seg=%h dp=%b required 1101 30 1", c, an_out, seg_out, dp_out);
        end
      end
      if (c >= 20 && c <= 25) begin
        checks++;
        if (an_out !== 4'hB || dp_out !== 1'b0) begin
          errors++; $display("FAIL digit2_dp c=%0d: an=%b dp=%b required 1011 0", c, an_out, dp_out);
        end
      end
      checks++;
      if (frame_tick !== ((c == 1 || c == 33 || c == 65) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL frame_tick c=%0d: got %b", c, frame_tick);
      end
    end
  endtask

  task automatic test_snapshot();
    obs_t e;
    bit   ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = (frame_tick === 1'b1); end
    checks++;
    if (!ok) begin errors++; $display("FAIL snap_tick_wait: frame_tick got 0 required 1"); end
    exp_q.delete();
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL snap_sb c=%0d: no expected entry", c);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL snap_sb c=%0d: got %h required %h", c, obs, e); end
      end
      if (c == 28) begin
        checks++;
        if (an_out !== 4'h7 || seg_out !== 7'h79) begin
          errors++; $display("FAIL snap_old c=%0d: an=%b seg=%h required 0111 79", c, an_out, seg_out);
        end
      end
      if (c == 36) begin
        checks++;
        if (an_out !== 4'hE || seg_out !== 7'h40) begin
          errors++; $display("FAIL snap_new0 c=%0d: an=%b seg=%h required 1110 40", c, an_out, seg_out);
        end
      end
      if (c == 60) begin
        checks++;
        if (an_out !== 4'h7 || seg_out !== 7'h12) begin
          errors++; $display("FAIL snap_new3 c=%0d: an=%b seg=%h required 0111 12", c, an_out, seg_out);
        end
      end
      if (c == 10) seg_in = {7'h6D, seg_in[20:7], 7'h3F};
    end
  endtask

  task automatic test_blank_mask();
    obs_t e;
    bit   ok = 0;
    int   dark = 0, lit3 = 0, lit0 = 0;
    blank_mask = 4'b1000;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = (frame_tick === 1'b1); end
    checks++;
    if (!ok) begin errors++; $display("FAIL mask_tick_wait: frame_tick got 0 required 1"); end
    exp_q.delete();
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL mask_sb c=%0d: no expected entry", c);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL mask_sb c=%0d: got %h required %h", c, obs, e); end
      end
      if (an_out === 4'hF) dark++;
      if (an_out === 4'h7) lit3++;
      if (an_out === 4'hE) lit0++;
    end
    checks++;
    if (dark != 14 || lit3 != 0 || lit0 != 6) begin
      errors++; $display("FAIL mask_counts: dark=%0d lit3=%0d lit0=%0d required 14 0 6", dark, lit3, lit0);
    end
    blank_mask = 4'b0000;
  endtask

  task automatic test_en_drop();
    obs_t e;
    bit   ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = (frame_tick === 1'b1); end
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_tick_wait: frame_tick got 0 required 1"); end
    exp_q.delete();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL drop_sb c=%0d: no expected entry", c);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL drop_sb c=%0d: got %h required %h", c, obs, e); end
      end
      if (c == 19) begin
        checks++;
        if (an_out !== 4'hB) begin errors++; $display("FAIL drop_pre: an=%b required 1011", an_out); end
        en = 1'b0;
      end
      if (c == 20) begin
        checks++;
        if (digit_idx !== 2'd0) begin errors++; $display("FAIL drop_idx: idx=%0d required 0", digit_idx); end
      end
      if (c == 21) begin
        checks++;
        if (an_out !== 4'hF) begin errors++; $display("FAIL drop_dark: an=%b required 1111", an_out); end
      end
      if (c == 23) en = 1'b1;
      if (c == 24) begin
        checks++;
        if (frame_tick !== 1'b1 || digit_idx !== 2'd0 || an_out !== 4'hF) begin
          errors++; $display("FAIL restart: tick=%b idx=%0d an=%b required 1 0 1111", frame_tick, digit_idx, an_out);
        end
      end
      if (c == 27) begin
        checks++;
        if (an_out !== 4'hE) begin errors++; $display("FAIL restart_show: an=%b required 1110", an_out); end
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    bit   ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (an_out !== 4'hF); end
    checks++;
    if (!ok) begin errors++; $display("FAIL areset_wait: an_out stayed 1111 for 20 cycles"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1 || digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
      errors++; $display("FAIL areset_off: an=%b seg=%h dp=%b idx=%0d tick=%b required 1111 7f 1 0 0",
                         an_out, seg_out, dp_out, digit_idx, frame_tick);
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL areset_sb c=%0d: no expected entry", c);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL areset_sb c=%0d: got %h required %h", c, obs, e); end
      end
      if (c == 4) begin
        checks++;
        if (an_out !== 4'hE) begin errors++; $display("FAIL areset_resume: an=%b required 1110", an_out); end
      end
    end
  endtask

  task automatic test_active_high();
    logic [6:0] seg0;
    int         dark = 0;
    seg0  = seg_in[6:0];
    en_hi = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (tick_hi !== 1'b1 || idx_hi !== 2'd0 || an_hi !== 4'h0) begin
          errors++; $display("FAIL hi_enter: tick=%b idx=%0d an=%b required 1 0 0000", tick_hi, idx_hi, an_hi);
        end
      end
      if (c >= 2 && c <= 9) begin
        checks++;
        if (an_hi !== 4'h1 || seg_hi !== seg0 || dp_hi !== dp_in[0]) begin
          errors++; $display("FAIL hi_digit0 c=%0d: an=%b seg=%h dp=%b required 0001 %h %b",
                             c, an_hi, seg_hi, dp_hi, seg0, dp_in[0]);
        end
      end
      if (c == 10) begin
        checks++;
        if (an_hi !== 4'h2) begin errors++; $display("FAIL hi_digit1: an=%b required 0010", an_hi); end
      end
      if (c >= 2 && c <= 33 && an_hi === 4'h0) dark++;
      if (c == 33) begin
        checks++;
        if (tick_hi !== 1'b1) begin errors++; $display("FAIL hi_tick: tick=%b required 1", tick_hi); end
      end
    end
    checks++;
    if (dark != 0) begin errors++; $display("FAIL hi_no_gap: dark cycles=%0d required 0", dark); end
    en_hi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_blank_mask();
    test_en_drop();
    test_async_reset();
    test_active_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
